// File: rtl/pic_bus_master_if.sv
// Host-side request/response signals and PIC system-bus strobes of the bus master.
interface pic_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic       cmd_a0;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       init_start;
  logic [7:0] icw1, icw2, icw3, icw4;
  logic       init_busy;
  logic       init_done;
  logic       inta_req;
  logic       inta_done;
  logic [7:0] inta_vector;
  logic       CS, RD, WR, A0, INTA;
  logic [7:0] output_sys_bus;
  logic       sys_bus_oe;
  logic [7:0] input_sys_bus;

  modport master (
    input  cmd_valid, cmd_rd, cmd_a0, cmd_wdata, init_start,
           icw1, icw2, icw3, icw4, inta_req, input_sys_bus,
    output cmd_ready, rsp_valid, rsp_rdata, init_busy, init_done,
           inta_done, inta_vector, CS, RD, WR, A0, INTA,
           output_sys_bus, sys_bus_oe
  );

  modport slave (
    output cmd_valid, cmd_rd, cmd_a0, cmd_wdata, init_start,
           icw1, icw2, icw3, icw4, inta_req, input_sys_bus,
    input  cmd_ready, rsp_valid, rsp_rdata, init_busy, init_done,
           inta_done, inta_vector, CS, RD, WR, A0, INTA,
           output_sys_bus, sys_bus_oe
  );
endinterface

// File: rtl/pic_bus_master.sv
// CPU-side initiator for the PIC read/write port: host read/write cycles,
// autonomous ICW1..ICW4 initialization and the two-pulse INTA cycle.
// Bus strobes are decoded from registered state only, so they change
// exactly on clock edges and drop immediately on reset.
module pic_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RECOV_CYC  = 2
) (
  input  logic            clk,
  input  logic            rst,
  pic_bus_master_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RECOV, INTA1, IGAP, INTA2
  } state_t;

  localparam logic [3:0] SETUP_L  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_L = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_L   = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [3:0] RECOV_L  = 4'(RECOV_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       started_q, rd_q, a0_q, init_cyc_q, pend_q, busy_q, done_q;
  logic [7:0] data_q, icw1_q, icw2_q, icw3_q, icw4_q;
  // pending init steps, bit n = ICW(n+1)
  logic [3:0] todo_q, todo_clr;
  logic       rsp_v_q, idone_q;
  logic [7:0] rdata_q, vec_q;
  logic       go_bus, go_inta, go_rd, go_a0, go_init, step_go, fin_init;
  logic [7:0] go_data;
  logic       start_ok, inta_pend, ready, in_bus;

  assign start_ok  = bus.init_start && !busy_q;
  assign inta_pend = pend_q || bus.inta_req;
  assign ready     = started_q && (state_q == IDLE) && !busy_q &&
                     !bus.init_start && !inta_pend;

  // Next state, counter reload and launch decisions (IDLE arbitration,
  // back-to-back chaining of init steps out of RECOV).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    go_bus   = 1'b0;
    go_inta  = 1'b0;
    go_rd    = 1'b0;
    go_a0    = 1'b0;
    go_init  = 1'b0;
    go_data  = '0;
    step_go  = 1'b0;
    fin_init = 1'b0;
    todo_clr = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          go_bus = 1'b1; go_init = 1'b1; go_data = bus.icw1;
        end else if (todo_q != 4'd0) begin
          step_go = 1'b1;
        end else if (inta_pend) begin
          go_inta = 1'b1;
        end else if (bus.cmd_valid && ready) begin
          go_bus = 1'b1; go_rd = bus.cmd_rd; go_a0 = bus.cmd_a0; go_data = bus.cmd_wdata;
        end
      end
      SETUP:
        if (cnt_q == 4'd0) begin state_d = STROBE; cnt_d = STROBE_L; end
        else cnt_d = cnt_q - 4'd1;
      STROBE:
        if (cnt_q == 4'd0) begin
          if (HOLD_CYC == 0) begin state_d = RECOV; cnt_d = RECOV_L; end
          else begin state_d = HOLD; cnt_d = HOLD_L; end
        end else cnt_d = cnt_q - 4'd1;
      HOLD:
        if (cnt_q == 4'd0) begin state_d = RECOV; cnt_d = RECOV_L; end
        else cnt_d = cnt_q - 4'd1;
      RECOV:
        if (cnt_q == 4'd0) begin
          if (init_cyc_q && todo_q != 4'd0) step_go = 1'b1;
          else begin state_d = IDLE; fin_init = init_cyc_q; end
        end else cnt_d = cnt_q - 4'd1;
      INTA1:
        if (cnt_q == 4'd0) begin state_d = IGAP; cnt_d = RECOV_L; end
        else cnt_d = cnt_q - 4'd1;
      IGAP:
        if (cnt_q == 4'd0) begin state_d = INTA2; cnt_d = STROBE_L; end
        else cnt_d = cnt_q - 4'd1;
      INTA2:
        if (cnt_q == 4'd0) begin state_d = RECOV; cnt_d = RECOV_L; end
        else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
    if (step_go) begin
      go_bus = 1'b1; go_init = 1'b1; go_a0 = 1'b1;
      if (todo_q[0])      begin go_data = icw1_q; go_a0 = 1'b0; todo_clr = 4'b0001; end
      else if (todo_q[1]) begin go_data = icw2_q; todo_clr = 4'b0010; end
      else if (todo_q[2]) begin go_data = icw3_q; todo_clr = 4'b0100; end
      else                begin go_data = icw4_q; todo_clr = 4'b1000; end
    end
    if (go_bus)  begin state_d = SETUP; cnt_d = SETUP_L;  end
    if (go_inta) begin state_d = INTA1; cnt_d = STROBE_L; end
  end

  // State register, cycle attributes, init sequencer and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  cnt_q <= '0;  started_q <= 1'b0;
      rd_q <= 1'b0;  a0_q <= 1'b0;  init_cyc_q <= 1'b0;  data_q <= '0;
      pend_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;  todo_q <= '0;
      icw1_q <= '0;  icw2_q <= '0;  icw3_q <= '0;  icw4_q <= '0;
      rsp_v_q <= 1'b0;  rdata_q <= '0;  idone_q <= 1'b0;  vec_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
      if (go_bus) begin
        a0_q <= go_a0;  rd_q <= go_rd;  init_cyc_q <= go_init;
        if (!go_rd) data_q <= go_data;
      end
      if (go_inta) init_cyc_q <= 1'b0;
      pend_q <= inta_pend && !go_inta;
      if (start_ok) begin
        icw1_q <= bus.icw1;  icw2_q <= bus.icw2;
        icw3_q <= bus.icw3;  icw4_q <= bus.icw4;
        // ICW1 goes out at once when launched straight from IDLE
        todo_q <= {bus.icw1[0], ~bus.icw1[1], 1'b1, state_q != IDLE};
        busy_q <= 1'b1;  done_q <= 1'b0;
      end else begin
        todo_q <= todo_q & ~todo_clr;
      end
      if (fin_init) begin busy_q <= 1'b0; done_q <= 1'b1; end
      rsp_v_q <= (state_q == STROBE) && (cnt_q == 4'd0) && rd_q;
      if ((state_q == STROBE) && (cnt_q == 4'd0) && rd_q) rdata_q <= bus.input_sys_bus;
      idone_q <= (state_q == INTA2) && (cnt_q == 4'd0);
      if ((state_q == INTA2) && (cnt_q == 4'd0)) vec_q <= bus.input_sys_bus;
    end
  end

  assign in_bus             = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign bus.CS             = !in_bus;
  assign bus.RD             = !((state_q == STROBE) && rd_q);
  assign bus.WR             = !((state_q == STROBE) && !rd_q);
  assign bus.INTA           = !((state_q == INTA1) || (state_q == INTA2));
  assign bus.A0             = a0_q;
  assign bus.output_sys_bus = data_q;
  assign bus.sys_bus_oe     = in_bus && !rd_q;
  assign bus.cmd_ready      = ready;
  assign bus.rsp_valid      = rsp_v_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.init_busy      = busy_q;
  assign bus.init_done      = done_q;
  assign bus.inta_done      = idone_q;
  assign bus.inta_vector    = vec_q;
endmodule
